wb_regfile_sb: RTL and testbench

- Destination end of the write-back path: 4 x 8-bit architectural register file.
- Accepts the WB stage's selected result plus destination register address; serves two combinational read ports to decode.
- Per-register pending-write scoreboard drives a decode stall on RAW hazards.
- Same-cycle write-to-read bypass removes one bubble when the producing write lands.

---
 rtl/wb_regfile_sb.sv | 102 ++++++++++
 tb/tb_wb_regfile_sb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile_sb.sv
// wb_regfile_sb: write-back destination register file with a RAW scoreboard.
//   clk, rst             : single clock, synchronous active-high reset
//   wb_wr_en/addr/data   : write-back result landing in the register file
//   rd_addr_a/b          : decode read addresses
//   rd_data_a/b          : combinational read data, bypassed from a same-cycle write
//   iss_*                : instruction presented by decode (sources used, destination)
//   stall                : combinational decode hold (RAW hazard or full pending counter)
//   sb_err               : sticky flag, write-back seen for a register with nothing pending
module wb_regfile_sb #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_wr_en,
    input  logic [ADDR_W-1:0] wb_wr_addr,
    input  logic [DATA_W-1:0] wb_wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              iss_valid,
    input  logic              iss_src_a_used,
    input  logic              iss_src_b_used,
    input  logic              iss_writes,
    input  logic [ADDR_W-1:0] iss_dst,
    output logic              stall,
    output logic              sb_err
);

    localparam int unsigned NREGS    = 1 << ADDR_W;
    localparam int unsigned MAX_PEND = (1 << CNT_W) - 1;

    logic [DATA_W-1:0] regs [NREGS];
    logic [CNT_W-1:0]  pend [NREGS];

    logic             byp_a;
    logic             byp_b;
    logic             haz_a;
    logic             haz_b;
    logic             full_d;
    logic             accepted;
    logic [NREGS-1:0] inc;
    logic [NREGS-1:0] dec;

    // Read ports with same-cycle write bypass
    always_comb begin
        byp_a     = wb_wr_en && (wb_wr_addr == rd_addr_a);
        byp_b     = wb_wr_en && (wb_wr_addr == rd_addr_b);
        rd_data_a = byp_a ? wb_wr_data : regs[rd_addr_a];
        rd_data_b = byp_b ? wb_wr_data : regs[rd_addr_b];
    end

    // Hazard and stall; a landing write clears the hazard only if it is the last one outstanding
    always_comb begin
        haz_a    = iss_src_a_used && (pend[rd_addr_a] != '0)
                   && !(byp_a && (pend[rd_addr_a] == CNT_W'(1)));
        haz_b    = iss_src_b_used && (pend[rd_addr_b] != '0)
                   && !(byp_b && (pend[rd_addr_b] == CNT_W'(1)));
        full_d   = iss_writes && (pend[iss_dst] == CNT_W'(MAX_PEND))
                   && !(wb_wr_en && (wb_wr_addr == iss_dst));
        stall    = iss_valid && (haz_a || haz_b || full_d);
        accepted = iss_valid && !stall && iss_writes;
    end

    // Per-register increment (accepted issue) and decrement (retiring write)
    always_comb begin
        inc = '0;
        dec = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            inc[r] = accepted && (iss_dst == ADDR_W'(r));
            dec[r] = wb_wr_en && (wb_wr_addr == ADDR_W'(r)) && (pend[r] != '0);
        end
    end

    // Register array, pending counters and sticky error; reset wins over a same-cycle write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
                pend[r] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            if (wb_wr_en) begin
                regs[wb_wr_addr] <= wb_wr_data;
                if (pend[wb_wr_addr] == '0) begin
                    sb_err <= 1'b1;
                end
            end
            for (int unsigned r = 0; r < NREGS; r++) begin
                if (inc[r] && !dec[r]) begin
                    pend[r] <= pend[r] + CNT_W'(1);
                end else if (dec[r] && !inc[r]) begin
                    pend[r] <= pend[r] - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Testbench for wb_regfile_sb: directed scenarios plus randomized traffic,
// checked against a behavioural model of register contents and outstanding writes.
module tb_wb_regfile_sb;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 2;
    localparam int unsigned CNT_W    = 2;
    localparam int          NREGS    = 4;
    localparam int          MAX_PEND = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_wr_en;
    logic [ADDR_W-1:0] wb_wr_addr;
    logic [DATA_W-1:0] wb_wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              iss_valid;
    logic              iss_src_a_used;
    logic              iss_src_b_used;
    logic              iss_writes;
    logic [ADDR_W-1:0] iss_dst;
    logic              stall;
    logic              sb_err;

    wb_regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_wr_en       (wb_wr_en),
        .wb_wr_addr     (wb_wr_addr),
        .wb_wr_data     (wb_wr_data),
        .rd_addr_a      (rd_addr_a),
        .rd_addr_b      (rd_addr_b),
        .rd_data_a      (rd_data_a),
        .rd_data_b      (rd_data_b),
        .iss_valid      (iss_valid),
        .iss_src_a_used (iss_src_a_used),
        .iss_src_b_used (iss_src_b_used),
        .iss_writes     (iss_writes),
        .iss_dst        (iss_dst),
        .stall          (stall),
        .sb_err         (sb_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: register values, writes still outstanding per register, error flag
    int m_regs [NREGS];
    int m_pend [NREGS];
    int m_err;

    // Values observed during the most recent step
    logic [DATA_W-1:0] obs_rd_a;
    logic [DATA_W-1:0] obs_rd_b;
    logic              obs_stall;
    logic              obs_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, sample and check at negedge, advance the model at posedge
    task automatic step(input logic r, input logic we, input int wa, input int wd,
                        input int ra, input int rb, input logic iv, input logic ua,
                        input logic ub, input logic iw, input int dst);
        int  exp_a, exp_b, left_a, left_b, left_d;
        bit  haz_a, haz_b, full, exp_stall, acc;
        rst            = r;
        wb_wr_en       = we;
        wb_wr_addr     = ADDR_W'(wa);
        wb_wr_data     = DATA_W'(wd);
        rd_addr_a      = ADDR_W'(ra);
        rd_addr_b      = ADDR_W'(rb);
        iss_valid      = iv;
        iss_src_a_used = ua;
        iss_src_b_used = ub;
        iss_writes     = iw;
        iss_dst        = ADDR_W'(dst);
        @(negedge clk);
        obs_rd_a  = rd_data_a;
        obs_rd_b  = rd_data_b;
        obs_stall = stall;
        obs_err   = sb_err;

        exp_a = (we && wa == ra) ? wd : m_regs[ra];
        exp_b = (we && wa == rb) ? wd : m_regs[rb];
        // Writes still outstanding once this cycle's landing write (if any) is counted as done
        left_a = m_pend[ra] - ((we && wa == ra && m_pend[ra] > 0) ? 1 : 0);
        left_b = m_pend[rb] - ((we && wa == rb && m_pend[rb] > 0) ? 1 : 0);
        left_d = m_pend[dst] - ((we && wa == dst && m_pend[dst] > 0) ? 1 : 0);
        haz_a = ua && (left_a > 0);
        haz_b = ub && (left_b > 0);
        full  = iw && (left_d >= MAX_PEND);
        exp_stall = iv && (haz_a || haz_b || full);
        acc = iv && !exp_stall && iw;

        if (!r) begin
            check("rd_data_a", 32'(obs_rd_a), 32'(exp_a));
            check("rd_data_b", 32'(obs_rd_b), 32'(exp_b));
            check("stall", 32'(obs_stall), 32'(exp_stall));
            check("sb_err", 32'(obs_err), 32'(m_err));
        end

        if (r) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] = 0;
                m_pend[i] = 0;
            end
            m_err = 0;
        end else begin
            if (we) begin
                if (m_pend[wa] == 0) m_err = 1;
                else m_pend[wa] = m_pend[wa] - 1;
                m_regs[wa] = wd;
            end
            if (acc) m_pend[dst] = m_pend[dst] + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        int we, wa, wd, ra, rb, iv, ua, ub, iw, dst;
        rst = 1'b1; wb_wr_en = 1'b0; wb_wr_addr = '0; wb_wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; iss_valid = 1'b0; iss_src_a_used = 1'b0;
        iss_src_b_used = 1'b0; iss_writes = 1'b0; iss_dst = '0;
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = 0;
            m_pend[i] = 0;
        end
        m_err = 0;

        // Reset then read every address
        do_reset();
        for (int a = 0; a < NREGS; a++) begin
            step(1'b0, 1'b0, 0, 0, a, 3 - a, 1'b0, 1'b0, 1'b0, 1'b0, 0);
            check("post_reset_rd", 32'(obs_rd_a), 32'h0);
            check("post_reset_stall", 32'(obs_stall), 32'h0);
            check("post_reset_err", 32'(obs_err), 32'h0);
        end

        // Write with bypass, then from the array; unsolicited write sets sb_err
        step(1'b0, 1'b1, 2, 'hA5, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("bypass_a", 32'(obs_rd_a), 32'hA5);
        check("bypass_b", 32'(obs_rd_b), 32'hA5);
        step(1'b0, 1'b0, 0, 0, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("array_rd", 32'(obs_rd_a), 32'hA5);
        check("err_set", 32'(obs_err), 32'h1);

        // RAW stall released by the landing write
        do_reset();
        step(1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1);
        check("issue_r1", 32'(obs_stall), 32'h0);
        step(1'b0, 1'b0, 0, 0, 1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("raw_stall", 32'(obs_stall), 32'h1);
        step(1'b0, 1'b0, 0, 0, 1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("raw_hold", 32'(obs_stall), 32'h1);
        step(1'b0, 1'b1, 1, 'h3C, 1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("raw_release", 32'(obs_stall), 32'h0);
        check("raw_bypass", 32'(obs_rd_a), 32'h3C);
        step(1'b0, 1'b0, 0, 0, 1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("raw_cleared", 32'(obs_stall), 32'h0);
        check("raw_no_err", 32'(obs_err), 32'h0);

        // Two outstanding writes: the first landing write does not release the reader
        step(1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 3);
        step(1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 3);
        step(1'b0, 1'b1, 3, 'h11, 3, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("dbl_first_wb", 32'(obs_stall), 32'h1);
        step(1'b0, 1'b1, 3, 'h22, 3, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("dbl_second_wb", 32'(obs_stall), 32'h0);
        check("dbl_bypass", 32'(obs_rd_a), 32'h22);

        // Counter saturation and its release by a same-cycle write
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
            check("sat_fill", 32'(obs_stall), 32'h0);
        end
        step(1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        check("sat_full", 32'(obs_stall), 32'h1);
        step(1'b0, 1'b1, 0, 'h5A, 1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        check("sat_wb_release", 32'(obs_stall), 32'h0);
        step(1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        check("sat_still_full", 32'(obs_stall), 32'h1);

        // Reset mid-flight drops the pending counts and the same-cycle write
        do_reset();
        step(1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 2);
        step(1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 2);
        step(1'b0, 1'b0, 0, 0, 2, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("mid_stall", 32'(obs_stall), 32'h1);
        step(1'b1, 1'b1, 2, 'hFF, 2, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0, 0, 2, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("mid_rd", 32'(obs_rd_a), 32'h0);
        check("mid_stall_drop", 32'(obs_stall), 32'h0);
        check("mid_err", 32'(obs_err), 32'h0);

        // Randomized traffic; write-backs mostly target registers with outstanding writes
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
                continue;
            end
            we  = ($urandom_range(0, 99) < 45) ? 1 : 0;
            wa  = int'($urandom_range(0, NREGS - 1));
            if ($urandom_range(0, 99) < 90) begin
                for (int t = 0; t < 4; t++) begin
                    if (m_pend[wa] == 0) wa = int'($urandom_range(0, NREGS - 1));
                end
            end
            wd  = int'($urandom_range(0, 255));
            ra  = int'($urandom_range(0, NREGS - 1));
            rb  = int'($urandom_range(0, NREGS - 1));
            iv  = ($urandom_range(0, 99) < 75) ? 1 : 0;
            ua  = int'($urandom_range(0, 1));
            ub  = int'($urandom_range(0, 1));
            iw  = ($urandom_range(0, 99) < 60) ? 1 : 0;
            dst = int'($urandom_range(0, NREGS - 1));
            step(1'b0, we[0], wa, wd, ra, rb, iv[0], ua[0], ub[0], iw[0], dst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
